imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, pipelined immediate generator and target adder for the decode stage. Accepts one instruction per cycle with its PC, control-supplied format select and a passthrough tag over a valid/ready handshake. Produces the XLEN-wide sign- or zero-extended immediate plus `pc + imm` two stages later. Sits between the decoder's control unit and the issue/branch unit, supports RV32/RV64 widths and formats the single-cycle extender lacks (CSR zimm, illegal-format flagging), and provides stall and flush handling.

## Interface
Parameters:
- `XLEN`, 32: datapath width; legal values are 32 and 64 only. Elaboration fails on any other value.
- `TAG_W`, 5: width of the opaque tag carried alongside each instruction (rd / ROB id).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous kill of all in-flight entries.
- `in_valid`  in  1  input entry valid.
- `in_ready`  out  1  block can accept this cycle.
- `in_instr`  in  32  raw instruction; bits [6:0] are ignored.
- `in_immsrc`  in  3  format select (see Operation).
- `in_pc`  in  XLEN  PC of the instruction.
- `in_tag`  in  TAG_W  passthrough tag.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  consumer accepts.
- `out_imm`  out  XLEN  extended immediate.
- `out_target`  out  XLEN  `pc + imm`, modulo 2^XLEN.
- `out_tag`  out  TAG_W  tag of the output entry.
- `out_illegal`  out  1  format select was 3'b111.

## Operation
Format encodings. "sext" means sign-extension from bit 31 to XLEN; "zext" means zero-extension.
- 000 I: sext `instr[31:20]`.
- 001 S: sext `{instr[31:25], instr[11:7]}`.
- 010 B: sext `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
- 011 J: sext `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
- 100 U: `{instr[31:12], 12'b0}`. Sign-extended from bit 31 when XLEN=64.
- 101 I-unsigned: zext `instr[31:20]`.
- 110 Z (CSR zimm): zext `instr[19:15]`.
- 111: imm = 0 and `illegal` = 1. The entry still flows through the pipeline; the block never drops it.

Pipeline:
- Stage 1 (S1) registers the extended immediate, `pc`, `tag` and `illegal`.
- Stage 2 (S2) registers `target = s1_pc + s1_imm`. The adder is XLEN wide and the carry-out is discarded, so the result wraps.
- S2 drives the outputs directly from its registers.

Handshake and flow:
- A transfer occurs when valid and ready are both high on the same edge.
- S2 advances when `!s2_valid || out_ready`.
- S1 advances into S2 when S2 advances.
- `in_ready = !s1_valid || s2_advances`. This is a combinational path from `out_ready` to `in_ready`; no skid buffer.
- Capacity is 2 entries. Order is strictly FIFO.
- While `out_valid` is high and `out_ready` is low, all `out_*` signals hold stable.

Flush:
- Clears `s1_valid` and `s2_valid` on the next edge.
- Has priority over any acceptance in the same cycle: an input presented during flush is dropped, even though `in_ready` may be high.
- Data registers are not cleared by flush.

Reset (`rstn` low, asynchronous): all valids = 0; `out_imm`, `out_target`, `out_tag`, `out_illegal` = 0; `in_ready` = 1 after deassertion. Reset mid-stream discards all entries.

## Timing
- Latency: an input accepted at edge N gives `out_valid` = 1 after edge N+2, presented in cycle N+2.
- Throughput: 1 entry/cycle with `out_ready` held high.
- Backpressure:
  - `out_ready` low with S1 and S2 full gives `in_ready` = 0 in the same cycle.
  - The first cycle `out_ready` returns high, `in_ready` = 1 combinationally.
- `flush` asserted in cycle N gives `out_valid` = 0 from cycle N+1. An entry accepted in N+1 emerges at N+3.
- `rstn` deassertion is synchronised externally; the block only requires a stable, active-low level.

## Test plan
- XLEN=32, I: instr 0xFFF00093, pc 0x100 -> 2 cycles later imm 0xFFFFFFFF, target 0x000000FF, illegal 0.
- B: instr 0xFE000EE3, pc 0x200 -> imm 0xFFFFFFFC, target 0x000001FC. J wrap: pc 0xFFFFFFFC, imm +8 -> target 0x00000004.
- XLEN=64, U: instr 0x800000B7 -> imm 0xFFFFFFFF80000000. Instr 0x123450B7 -> 0x0000000012345000. Z: instr[19:15]=0x1F -> imm 0x1F. Sel 111 -> imm 0, illegal 1.
- Backpressure: stream 4 entries, tags 1..4; hold `out_ready` low 3 cycles -> `in_ready` falls after 2 are accepted, outputs stable, tags emerge 1,2,3,4 with none lost or duplicated.
- Flush: flush in the cycle S1 and S2 are full and `in_valid` is high -> no output for any of those 3 entries. Next entry appears exactly 2 cycles after its acceptance.
- Async reset mid-stream: pull `rstn` low between edges -> `out_valid` and data go to 0 immediately; after release `in_ready` = 1 and the next entry has a 2-cycle latency.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage immediate extender and pc+imm target adder
// for the decode stage, valid/ready handshake on both sides.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_B   = 3'b010,
    FMT_J   = 3'b011,
    FMT_U   = 3'b100,
    FMT_IU  = 3'b101,
    FMT_Z   = 3'b110,
    FMT_BAD = 3'b111
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } s1_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  target;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } s2_t;

  logic [31:0]     raw;
  logic            sx;
  logic            bad;
  logic [XLEN-1:0] ext;

  logic s1_valid;
  logic s2_valid;
  logic s2_adv;
  logic accept;
  s1_t  s1;
  s2_t  s2;

  // raw is the 32-bit immediate; sx says whether it extends past bit 31
  always_comb begin
    raw = '0;
    sx  = 1'b1;
    bad = 1'b0;
    unique case (fmt_e'(in_immsrc))
      FMT_I: raw = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: raw = {{20{in_instr[31]}}, in_instr[31:25],
                    in_instr[11:7]};
      FMT_B: raw = {{19{in_instr[31]}}, in_instr[31],
                    in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
      FMT_J: raw = {{11{in_instr[31]}}, in_instr[31],
                    in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
      FMT_U: raw = {in_instr[31:12], 12'b0};
      FMT_IU: begin
        raw = {20'b0, in_instr[31:20]};
        sx  = 1'b0;
      end
      FMT_Z: begin
        raw = {27'b0, in_instr[19:15]};
        sx  = 1'b0;
      end
      FMT_BAD: begin
        raw = '0;
        bad = 1'b1;
      end
    endcase
  end

  assign ext = sx ? XLEN'($signed(raw)) : XLEN'(raw);

  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (in_ready) s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= '0;
    end else if (accept) begin
      s1.imm     <= ext;
      s1.pc      <= in_pc;
      s1.tag     <= in_tag;
      s1.illegal <= bad;
    end
  end

  // carry-out of the target adder is dropped, so targets wrap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2 <= '0;
    end else if (s2_adv && s1_valid) begin
      s2.imm     <= s1.imm;
      s2.target  <= s1.pc + s1.imm;
      s2.tag     <= s1.tag;
      s2.illegal <= s1.illegal;
    end
  end

  assign out_valid   = s2_valid;
  assign out_imm     = s2.imm;
  assign out_target  = s2.target;
  assign out_tag     = s2.tag;
  assign out_illegal = s2.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe at XLEN=32 and 64.
// Both instances share stimulus; the 64-bit one gets the full pc.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic [63:0] pc;
  logic [4:0]  tag;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32, tgt32;
  logic [4:0]  tag32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64, tgt64;
  logic [4:0]  tag64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(instr), .in_immsrc(immsrc),
    .in_pc(pc[31:0]), .in_tag(tag),
    .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_target(tgt32),
    .out_tag(tag32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(instr), .in_immsrc(immsrc),
    .in_pc(pc), .in_tag(tag),
    .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_target(tgt64),
    .out_tag(tag64), .out_illegal(ill64)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] i, input logic [2:0] s,
                       input logic [63:0] p, input logic [4:0] t);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr = i; immsrc = s; pc = p; tag = t;
    cyc();
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rstn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; immsrc = '0; pc = '0; tag = '0;
    #1 rstn = 1'b0;
    #2;
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL rst_valid32 got=%b exp=0", ov32); end
    checks++; if (imm32 !== 32'h0) begin errors++; $display("FAIL rst_imm32 got=%h exp=0", imm32); end
    checks++; if (tgt32 !== 32'h0) begin errors++; $display("FAIL rst_tgt32 got=%h exp=0", tgt32); end
    checks++; if (tag32 !== 5'h0 || ill32 !== 1'b0) begin errors++; $display("FAIL rst_tag_ill got=%h/%b exp=0/0", tag32, ill32); end
    checks++; if (ov64 !== 1'b0 || imm64 !== 64'h0) begin errors++; $display("FAIL rst_64 got=%b/%h exp=0/0", ov64, imm64); end
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    #1;
    checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", rdy32); end
    cyc();
  endtask

  task automatic test_imm32();
    send1(32'hFFF00093, 3'b000, 64'h100, 5'd3);
    checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL i_valid got=%b exp=1", ov32); end
    checks++; if (imm32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL i_imm got=%h exp=ffffffff", imm32); end
    checks++; if (tgt32 !== 32'h000000FF) begin errors++; $display("FAIL i_tgt got=%h exp=000000ff", tgt32); end
    checks++; if (ill32 !== 1'b0 || tag32 !== 5'd3) begin errors++; $display("FAIL i_ill_tag got=%b/%0d exp=0/3", ill32, tag32); end
    checks++; if (imm64 !== 64'hFFFFFFFF_FFFFFFFF || tgt64 !== 64'hFF) begin errors++; $display("FAIL i_64 got=%h/%h exp=all-ones/ff", imm64, tgt64); end
    send1(32'hFE000EE3, 3'b010, 64'h200, 5'd4);
    checks++; if (imm32 !== 32'hFFFFFFFC) begin errors++; $display("FAIL b_imm got=%h exp=fffffffc", imm32); end
    checks++; if (tgt32 !== 32'h000001FC) begin errors++; $display("FAIL b_tgt got=%h exp=000001fc", tgt32); end
    send1(32'hFE000C23, 3'b001, 64'h1000, 5'd5);
    checks++; if (imm32 !== 32'hFFFFFFF8 || tgt32 !== 32'h00000FF8) begin errors++; $display("FAIL s_imm_tgt got=%h/%h exp=fffffff8/00000ff8", imm32, tgt32); end
    send1(32'h0080006F, 3'b011, 64'hFFFFFFFC, 5'd6);
    checks++; if (imm32 !== 32'h8) begin errors++; $display("FAIL j_imm got=%h exp=00000008", imm32); end
    checks++; if (tgt32 !== 32'h4) begin errors++; $display("FAIL j_wrap got=%h exp=00000004", tgt32); end
    checks++; if (tgt64 !== 64'h1_00000004) begin errors++; $display("FAIL j_tgt64 got=%h exp=0000000100000004", tgt64); end
  endtask

  task automatic test_imm64();
    send1(32'h800000B7, 3'b100, 64'h0, 5'd1);
    checks++; if (imm64 !== 64'hFFFFFFFF_80000000) begin errors++; $display("FAIL u_neg64 got=%h exp=ffffffff80000000", imm64); end
    checks++; if (imm32 !== 32'h80000000) begin errors++; $display("FAIL u_neg32 got=%h exp=80000000", imm32); end
    send1(32'h123450B7, 3'b100, 64'h0, 5'd2);
    checks++; if (imm64 !== 64'h00000000_12345000) begin errors++; $display("FAIL u_pos64 got=%h exp=0000000012345000", imm64); end
    send1(32'h800F8073, 3'b110, 64'h0, 5'd3);
    checks++; if (imm64 !== 64'h1F || imm32 !== 32'h1F) begin errors++; $display("FAIL z_imm got=%h/%h exp=1f/1f", imm64, imm32); end
    send1(32'hFFF00093, 3'b101, 64'h0, 5'd4);
    checks++; if (imm64 !== 64'hFFF || imm32 !== 32'hFFF) begin errors++; $display("FAIL iu_imm got=%h/%h exp=fff/fff", imm64, imm32); end
    send1(32'hFFFFFFFF, 3'b111, 64'h40, 5'd5);
    checks++; if (ov64 !== 1'b1 || ill64 !== 1'b1 || imm64 !== 64'h0) begin errors++; $display("FAIL bad_64 got=%b/%b/%h exp=1/1/0", ov64, ill64, imm64); end
    checks++; if (ill32 !== 1'b1 || imm32 !== 32'h0 || tgt32 !== 32'h40) begin errors++; $display("FAIL bad_32 got=%b/%h/%h exp=1/0/40", ill32, imm32, tgt32); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bi [3] = '{32'h00500093, 32'hFE000C23, 32'h123450B7};
    logic [2:0]  bs [3] = '{3'b000, 3'b001, 3'b100};
    logic [63:0] bp [3] = '{64'h10, 64'h1000, 64'h10};
    logic [31:0] ei [3] = '{32'h5, 32'hFFFFFFF8, 32'h12345000};
    logic [31:0] et [3] = '{32'h15, 32'hFF8, 32'h12345010};
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 3);
      if (c < 3) begin
        instr = bi[c]; immsrc = bs[c]; pc = bp[c]; tag = 5'(7 + c);
      end
      #1;
      if (c >= 2 && c < 5) begin
        checks++; if (ov32 !== 1'b1 || tag32 !== 5'(5 + c)) begin errors++; $display("FAIL b2b_valid_tag c=%0d got=%b/%0d exp=1/%0d", c, ov32, tag32, 5 + c); end
        checks++; if (imm32 !== ei[c-2] || tgt32 !== et[c-2]) begin errors++; $display("FAIL b2b_data c=%0d got=%h/%h exp=%h/%h", c, imm32, tgt32, ei[c-2], et[c-2]); end
      end
      if (c == 5) begin
        checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", ov32); end
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    int nxt = 1;
    int exp = 1;
    pc = '0;
    immsrc = 3'b000;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 2 && c < 5);
      in_valid  = (nxt <= 4);
      tag   = 5'(nxt);
      instr = {12'(nxt * 3), 20'h00093};
      #1;
      if (c == 2) begin
        checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", rdy32); end
      end
      if (c >= 2 && c < 5) begin
        checks++; if (ov32 !== 1'b1 || tag32 !== 5'd1 || imm32 !== 32'd3) begin errors++; $display("FAIL bp_hold c=%0d got=%b/%0d/%h exp=1/1/3", c, ov32, tag32, imm32); end
      end
      if (c == 5) begin
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", rdy32); end
      end
      if (ov32 && out_ready) begin
        checks++; if (tag32 !== 5'(exp) || imm32 !== 32'(exp * 3)) begin errors++; $display("FAIL bp_order got=%0d/%h exp=%0d/%h", tag32, imm32, exp, exp * 3); end
        exp++;
      end
      if (in_valid && rdy32) nxt++;
      cyc();
    end
    in_valid = 1'b0;
    checks++; if (exp !== 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", exp - 1); end
  endtask

  task automatic test_flush();
    immsrc = 3'b000; instr = 32'h00100093; pc = 64'h0;
    out_ready = 1'b0;
    in_valid = 1'b1; tag = 5'd10;
    cyc();
    tag = 5'd11;
    cyc();
    tag = 5'd12; flush = 1'b1;
    #1;
    checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL fl_full got=%b exp=1", ov32); end
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL fl_cleared got=%b exp=0", ov32); end
    cyc();
    in_valid = 1'b1; tag = 5'd14; flush = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL fl_ready got=%b exp=1", rdy32); end
    cyc();
    flush = 1'b0; tag = 5'd13;
    #1;
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL fl_empty got=%b exp=0", ov32); end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL fl_dropped got=%b exp=0", ov32); end
    cyc();
    checks++; if (ov32 !== 1'b1 || tag32 !== 5'd13) begin errors++; $display("FAIL fl_next got=%b/%0d exp=1/13", ov32, tag32); end
    cyc();
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL fl_drain got=%b exp=0", ov32); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1; immsrc = 3'b000; instr = 32'h00100093;
    pc = 64'h50;
    in_valid = 1'b1; tag = 5'd20;
    cyc();
    tag = 5'd21;
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (ov32 !== 1'b1 || tag32 !== 5'd20) begin errors++; $display("FAIL ar_pre got=%b/%0d exp=1/20", ov32, tag32); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (ov32 !== 1'b0 || imm32 !== 32'h0 || tgt32 !== 32'h0 || tag32 !== 5'h0) begin errors++; $display("FAIL ar_clear32 got=%b/%h/%h/%0d exp=0/0/0/0", ov32, imm32, tgt32, tag32); end
    checks++; if (ov64 !== 1'b0 || tgt64 !== 64'h0) begin errors++; $display("FAIL ar_clear64 got=%b/%h exp=0/0", ov64, tgt64); end
    cyc();
    #2 rstn = 1'b1;
    #1;
    checks++; if (rdy32 !== 1'b1 || ov32 !== 1'b0) begin errors++; $display("FAIL ar_release got=%b/%b exp=1/0", rdy32, ov32); end
    cyc();
    in_valid = 1'b1; tag = 5'd22;
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL ar_lat1 got=%b exp=0", ov32); end
    cyc();
    checks++; if (ov32 !== 1'b1 || tag32 !== 5'd22 || tgt32 !== 32'h51) begin errors++; $display("FAIL ar_lat2 got=%b/%0d/%h exp=1/22/51", ov32, tag32, tgt32); end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_imm32();
    test_imm64();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
